// File: rtl/fp_divider.sv
// fp_divider: iterative IEEE-754 binary32 divider.
// Restoring mantissa division (one quotient bit per cycle, 26 cycles), then
// one normalise/pack cycle. Fixed 28-cycle latency from accept to done.
// Optional macro FP_DIV_RNE_EN: round-to-nearest-even in NORM (default truncates).
module fp_divider (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, DIV, NORM} state_e;
  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} spec_e;

  state_e             state_q, state_d;
  spec_e              spec_q, spec_d;
  logic               dbz_pend_q, dbz_pend_d;
  logic               sign_q;
  logic [23:0]        mb_q;
  logic signed [9:0]  ediff_q;
  logic [24:0]        rem_q;
  logic [25:0]        quo_q;
  logic [4:0]         cnt_q;
  logic               done_q, dbz_q;
  logic [31:0]        result_q, result_d;

  logic accept;
  assign accept = start && (state_q == IDLE);

  // Operand classification, evaluated on the raw inputs so it can be latched at accept.
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  assign a_zero = (a[30:23] == 8'h00);
  assign a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
  assign a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  assign b_zero = (b[30:23] == 8'h00);
  assign b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
  assign b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);

  // Special-case outcome; denormals already count as zero through a_zero/b_zero.
  always_comb begin
    spec_d     = SP_NONE;
    dbz_pend_d = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_d = SP_NAN;
    end else if (b_zero && !a_inf) begin
      spec_d     = SP_INF;
      dbz_pend_d = 1'b1;
    end else if (a_inf) begin
      spec_d = SP_INF;
    end else if (a_zero || b_inf) begin
      spec_d = SP_ZERO;
    end
  end

  // One restoring-division step: compare, conditionally subtract, shift.
  logic        q_bit;
  logic [24:0] rem_sub, rem_nxt;
  always_comb begin
    q_bit   = (rem_q >= {1'b0, mb_q});
    rem_sub = q_bit ? (rem_q - {1'b0, mb_q}) : rem_q;
    rem_nxt = rem_sub << 1;
  end

  // Normalise the quotient, optionally round, then range-check and pack.
  logic [22:0]       frac_n, frac_r;
  logic signed [9:0] exp_n, exp_r;
`ifdef FP_DIV_RNE_EN
  logic        guard, sticky;
  logic [23:0] frac_sum;
`endif
  always_comb begin
    if (quo_q[25]) begin
      frac_n = quo_q[24:2];
      exp_n  = ediff_q + 10'sd127;
    end else begin
      frac_n = quo_q[23:1];
      exp_n  = ediff_q + 10'sd126;
    end
`ifdef FP_DIV_RNE_EN
    guard    = quo_q[25] ? quo_q[1] : quo_q[0];
    sticky   = (quo_q[25] & quo_q[0]) | (rem_q != 25'd0);
    frac_sum = {1'b0, frac_n} + {23'd0, guard & (sticky | frac_n[0])};
    // Carry out of the fraction means the significand rolled over to 2.0.
    if (frac_sum[23]) begin
      frac_r = 23'd0;
      exp_r  = exp_n + 10'sd1;
    end else begin
      frac_r = frac_sum[22:0];
      exp_r  = exp_n;
    end
`else
    frac_r = frac_n;
    exp_r  = exp_n;
`endif
    case (spec_q)
      SP_NAN:  result_d = 32'h7FC0_0000;
      SP_INF:  result_d = {sign_q, 8'hFF, 23'd0};
      SP_ZERO: result_d = {sign_q, 31'd0};
      default: begin
        if (exp_r >= 10'sd255)     result_d = {sign_q, 8'hFF, 23'd0};
        else if (exp_r <= 10'sd0)  result_d = {sign_q, 31'd0};
        else                       result_d = {sign_q, exp_r[7:0], frac_r};
      end
    endcase
  end

  // Control FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = DIV;
      DIV:     if (cnt_q == 5'd25) state_d = NORM;
      NORM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath: operand capture, iteration and result/flag registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      spec_q     <= SP_NONE;
      dbz_pend_q <= 1'b0;
      sign_q     <= 1'b0;
      mb_q       <= 24'd0;
      ediff_q    <= 10'sd0;
      rem_q      <= 25'd0;
      quo_q      <= 26'd0;
      cnt_q      <= 5'd0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      result_q   <= 32'd0;
    end else begin
      done_q <= (state_q == NORM);
      if (accept) begin
        spec_q     <= spec_d;
        dbz_pend_q <= dbz_pend_d;
        sign_q     <= a[31] ^ b[31];
        mb_q       <= {1'b1, b[22:0]};
        ediff_q    <= $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]});
        rem_q      <= {2'b01, a[22:0]};
        quo_q      <= 26'd0;
        cnt_q      <= 5'd0;
      end else if (state_q == DIV) begin
        rem_q <= rem_nxt;
        quo_q <= {quo_q[24:0], q_bit};
        cnt_q <= cnt_q + 5'd1;
      end else if (state_q == NORM) begin
        result_q <= result_d;
        dbz_q    <= dbz_pend_q;
      end
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp_divider.sv
// tb_fp_divider: directed vector table plus handshake/reset sequences for fp_divider.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  fp_divider dut (
    .clk(clk), .rstn(rstn), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        dbz;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the accepting edge (cycle 1).
  task automatic launch(input logic [31:0] va, input logic [31:0] vb);
    a = va; b = vb; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles since accept until done is seen; gives up at 60.
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n, ndone, dcyc;
    logic [31:0] third;
`ifdef FP_DIV_RNE_EN
    third = 32'h3EAA_AAAB;
`else
    third = 32'h3EAA_AAAA;
`endif
    vecs[0]  = '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0}; // 6/2
    vecs[1]  = '{32'h3F80_0000, 32'h4040_0000, third,         1'b0}; // 1/3
    vecs[2]  = '{32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b1}; // -1/0
    vecs[3]  = '{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0}; // 0/0
    vecs[4]  = '{32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 1'b0}; // overflow
    vecs[5]  = '{32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 1'b0}; // underflow
    vecs[6]  = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0}; // 1/1
    vecs[7]  = '{32'h40A0_0000, 32'hC000_0000, 32'hC020_0000, 1'b0}; // 5/-2
    vecs[8]  = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0}; // -inf/2
    vecs[9]  = '{32'h4000_0000, 32'h7F80_0000, 32'h0000_0000, 1'b0}; // 2/inf
    vecs[10] = '{32'h4040_0000, 32'h7FC0_0001, 32'h7FC0_0000, 1'b0}; // 3/NaN
    vecs[11] = '{32'hFF80_0000, 32'h7F80_0000, 32'h7FC0_0000, 1'b0}; // inf/inf
    vecs[12] = '{32'h8000_0001, 32'h40A0_0000, 32'h8000_0000, 1'b0}; // -denorm/5

    rstn = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_busy",   {31'd0, busy},        32'd0);
    check("reset_done",   {31'd0, done},        32'd0);
    check("reset_result", result,               32'd0);
    check("reset_dbz",    {31'd0, div_by_zero}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      launch(vecs[i].a, vecs[i].b);
      if (i == 0) check("busy_after_accept", {31'd0, busy}, 32'd1);
      wait_done(n);
      check($sformatf("latency[%0d]", i), n, 28);
      check($sformatf("result[%0d]", i), result, vecs[i].res);
      check($sformatf("dbz[%0d]", i), {31'd0, div_by_zero}, {31'd0, vecs[i].dbz});
      if (i == 0) check("busy_in_done_cycle", {31'd0, busy}, 32'd0);
      @(negedge clk);
      if (i == 0) check("done_one_cycle", {31'd0, done}, 32'd0);
    end

    // start pulsed at cycle 10 with new operands must be ignored.
    launch(32'h40C0_0000, 32'h4000_0000);
    repeat (9) @(negedge clk);
    a = 32'h3F80_0000; b = 32'h4040_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; dcyc = 0;
    for (int c = 11; c <= 70; c++) begin
      if (done) begin ndone++; dcyc = c; end
      @(negedge clk);
    end
    check("ignored_start_ndone", ndone, 1);
    check("ignored_start_cycle", dcyc, 28);
    check("ignored_start_result", result, 32'h4040_0000);

    // Back-to-back: start in the done cycle is accepted.
    launch(32'h3F80_0000, 32'h3F80_0000);
    wait_done(n);
    check("b2b_first_latency", n, 28);
    check("b2b_first_result", result, 32'h3F80_0000);
    launch(32'h40A0_0000, 32'hC000_0000);
    wait_done(n);
    check("b2b_second_latency", n, 28);
    check("b2b_second_result", result, 32'hC020_0000);
    @(negedge clk);

    // Reset mid-operation aborts with no done pulse.
    launch(32'hBF80_0000, 32'h0000_0000);
    repeat (14) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("abort_busy",   {31'd0, busy},        32'd0);
    check("abort_done",   {31'd0, done},        32'd0);
    check("abort_result", result,               32'd0);
    check("abort_dbz",    {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("abort_no_done", ndone, 0);
    check("abort_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_divider.md
# fp_divider

Iterative IEEE-754 single-precision divider for the floating-point arithmetic unit, the inverse-operation counterpart of the mantissa multiplier/normaliser path. It accepts two packed 32-bit operands on a start pulse and runs a restoring mantissa division, one quotient bit per cycle. It then normalises the quotient, computes the exponent and returns a packed 32-bit result with a one-cycle done pulse. It sits beside the multiplier, behind the same operand registers, and feeds the same result mux.

## Interface
- No parameters; the width is fixed at binary32.
- clk  in  1  Single clock; all state updates on the rising edge.
- rstn  in  1  Reset, asynchronous, active-low.
- start  in  1  Request; sampled only while busy=0.
- a  in  32  Dividend, IEEE-754 single.
- b  in  32  Divisor, IEEE-754 single.
- busy  out  1  High while an operation is in flight.
- done  out  1  One-cycle pulse; result is valid from this cycle on.
- result  out  32  Quotient; held stable until the next done.
- div_by_zero  out  1  Set with done when a is finite and non-zero and b is zero; held with result.

## Operation
- FSM: IDLE -> DIV (26 cycles) -> NORM (1 cycle) -> IDLE.
  - The done pulse is issued on the NORM->IDLE transition edge.
- Accept: on a rising edge with start=1 and busy=0, the block:
  - registers a and b;
  - computes sign = a[31]^b[31];
  - loads ma={1,a[22:0]} and mb={1,b[22:0]}, both 24 bits;
  - loads the 10-bit signed exponent difference ea-eb;
  - enters DIV.
- Denormal inputs (exp=0) are treated as signed zero; no denormal outputs are produced.
- Each DIV cycle, with a 25-bit remainder R (initialised to ma):
  - if R>=mb then q_bit=1 and R=R-mb, else q_bit=0;
  - R=R<<1;
  - q_bit is shifted into the 26-bit q, MSB first.
- NORM:
  - If q[25]=1: sig=q[25:2], guard=q[1], sticky=q[0]|(R!=0), exponent=ea-eb+127.
  - Else: sig=q[24:1], guard=q[0], sticky=(R!=0), exponent=ea-eb+126.
  - Exponent >=255 gives a signed infinity.
  - Exponent <=0 gives a signed zero (flush).
  - Otherwise result={sign, exponent[7:0], sig[22:0]}.
- Special cases are resolved at accept and applied in NORM. The DIV cycles still run, so latency stays fixed.
  - NaN operand, 0/0, or inf/inf: 0x7FC00000, sign forced to 0.
  - Finite non-zero / 0: signed infinity, div_by_zero=1.
  - inf / finite: signed infinity.
  - 0 / non-zero, or finite / inf: signed zero.
- div_by_zero is 0 for every case not listed above.

## Timing
- Reset values: busy=0, done=0, result=32'h0, div_by_zero=0, FSM=IDLE, q=0, R=0.
- Latency: start is accepted at edge E0; done=1 in the cycle after edge E27, i.e. 28 cycles, identical for all operands.
- busy is 1 from the cycle after E0 through the NORM cycle. busy is 0 in the done cycle.
- Back-to-back: start asserted in the done cycle is accepted, so one result is produced every 28 cycles.
- start while busy=1 is ignored; no queueing and no error.
- a and b are registered at accept, so changing them after accept has no effect.
- Reset asserted mid-operation aborts immediately: all outputs return to their reset values, no done pulse is issued, and the FSM returns to IDLE.

## Configuration
- Macro: FP_DIV_RNE_EN.
- Defined: NORM rounds to nearest-even.
  - Increment sig when guard & (sticky | sig[0]).
  - On carry-out, sig=1.0 and the exponent increments; if this makes the exponent 255, the result is a signed infinity.
  - Latency is unchanged.
- Undefined: truncate (round toward zero). guard and sticky are ignored, matching the multiplier's truncating fraction path.

## Test plan
- a=0x40C00000 (6.0), b=0x40000000 (2.0) -> result=0x40400000, done exactly 28 cycles after accept, div_by_zero=0.
- a=0x3F800000, b=0x40400000 (1/3) -> result=0x3EAAAAAA without FP_DIV_RNE_EN; 0x3EAAAAAB with it.
- Special cases:
  - a=0xBF800000, b=0x00000000 -> result=0xFF800000, div_by_zero=1.
  - a=0, b=0 -> result=0x7FC00000, div_by_zero=0.
- Exponent range:
  - a=0x7F000000, b=0x3E800000 (overflow) -> 0x7F800000.
  - a=0x00800000, b=0x7F000000 (underflow) -> 0x00000000.
- Handshake and reset:
  - start pulsed again at cycle 10 of an operation -> ignored; exactly one done at cycle 28.
  - start in the done cycle -> accepted; second done at +28.
  - rstn low at cycle 15 -> busy/done/result=0; no done pulse follows.
